ps2_kbd_rx_fifo: RTL and testbench
==================================

// Module: ps2_kbd_rx_fifo
// PURPOSE
//   Parametrised PS/2 keyboard receiver with a scancode FIFO.
//   - Deserialises 11-bit device-to-host frames and folds E0/F0 prefixes into flags.
//   - Pushes one tagged word per key event into a FWFT FIFO, so bursts are not lost
//     while the game logic is busy.
//   - Sits between the PS/2 pins and the snake-game controller; no ASCII translation.
// PARAMETERS
//   CLK_HZ      50_000_000  system clock frequency
//   TIMEOUT_US  120         ps2_clk inactivity (us) that aborts a partial frame
//   FIFO_DEPTH  8           FIFO entries; power of 2, >= 2
//   SYNC_STAGES 2           synchroniser flops on ps2_clk/ps2_data, >= 2
//   DROP_ERR    1           1: discard bad frames; 0: push them with err=1
// PORTS
//   clk        in   1                      system clock
//   rst        in   1                      reset, asynchronous, active-high
//   ps2_clk    in   1                      PS/2 clock pin, async
//   ps2_data   in   1                      PS/2 data pin, async
//   rd_en      in   1                      pop head word (ignored when empty)
//   rd_valid   out  1                      FIFO not empty; rd_data valid
//   rd_data    out  11                     {err, extended, released, code[7:0]}
//   count      out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//   overflow   out  1                      sticky: a word was dropped because the FIFO was full
//   clr_ovf    in   1                      clears overflow
// BEHAVIOUR
//   Reset values
//   - Outputs: rd_valid=0, rd_data=0, count=0, overflow=0.
//   - Internal: synchronisers=1, bit counter=0, prefix flags=0.
//   Frame capture
//   - Falling edge = synchronised ps2_clk goes 1->0. On each edge, shift ps2_data
//     LSB-first into an 11-bit register; bit_cnt++.
//   - TMAX = CLK_HZ/1_000_000*TIMEOUT_US. The timer clears on every ps2_clk edge
//     and saturates at TMAX.
//   - At TMAX with bit_cnt != 0: bit_cnt=0, the partial frame is discarded, prefix
//     flags are unchanged.
//   Frame check (bit_cnt == 11, one-cycle frame_done)
//   - frm_err = (start != 0) | (stop != 1) | (even parity over data+parity bit).
//   - bit_cnt returns to 0 in the same cycle.
//   Prefix handling (on frame_done, good frame)
//   - code E0: set ext. Code F0: set rel. No push for either.
//   - Any other code: push {0, ext, rel, code}, then clear ext and rel.
//   - Bad frame, DROP_ERR=1: no push; clear ext and rel.
//   - Bad frame, DROP_ERR=0: push {1, ext, rel, code}; clear ext and rel.
//   Latency
//   - Word is written on the frame_done cycle; rd_valid is high on the next clk.
//   - Total: <= SYNC_STAGES+3 clk after the 11th pin falling edge.
//   FIFO (first-word-fall-through)
//   - rd_data always shows the head word; rd_en && rd_valid pops it at the clk edge.
//   - Push when full without a pop: word dropped, overflow=1, count unchanged.
//   - Push and pop in the same cycle: both happen, including when full; count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; count is saturating-safe (0..FIFO_DEPTH).
//   - clr_ovf and a new overflow in the same cycle: overflow stays 1.
//   Reset mid-frame
//   - Asynchronous clear of all state.
//   - The next frame is captured only from a fresh start bit after rst deasserts.
// STRUCTURE
//   Package ps2_pkg
//   - Constants: FRAME_BITS=11, RELEASE_CODE=8'hF0, EXTENDED_CODE=8'hE0.
//   - Field positions: ERR_BIT=10, EXT_BIT=9, REL_BIT=8.
//   Sub-module ps2_sync_fifo #(WIDTH=11, DEPTH)
//   - Generic FWFT FIFO: push/full/pop/empty/count.
//   - Frame capture, timeout and prefix logic stay in the top module.
// TESTING
//   1. Key 'A' make 0x1C, then break F0 1C:
//      -> words 0x01C then 0x11C; count=2; prefix produces no push.
//   2. E0 75 then E0 F0 75 (up arrow):
//      -> words 0x275 then 0x375; ext and rel cleared after each.
//   3. Frame 0x1C with a flipped parity bit:
//      - DROP_ERR=1 -> no push, count=0.
//      - DROP_ERR=0 -> word 0x41C.
//   4. Send 6 ps2_clk pulses, idle 150 us, then a full 0x29 frame:
//      -> single word 0x029; partial frame discarded.
//   5. FIFO_DEPTH=4, 5 make codes with no reads:
//      -> count=4, overflow=1, head=first code.
//      - Pop during the 6th push -> count stays 4.
//      - clr_ovf -> overflow=0.
//   6. Assert rst after bit 5 of a frame, then send 0x16:
//      -> all outputs at reset values during rst; only word 0x016 after.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, word layout and frame-check helper for the PS/2 keyboard receiver.
package ps2_pkg;
  localparam int         FRAME_BITS    = 11;
  localparam logic [7:0] RELEASE_CODE  = 8'hF0;
  localparam logic [7:0] EXTENDED_CODE = 8'hE0;
  localparam int         ERR_BIT       = 10;
  localparam int         EXT_BIT       = 9;
  localparam int         REL_BIT       = 8;

  typedef struct packed {
    logic       err;
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_word_t;

  // Frame layout LSB-first: [0]=start, [8:1]=data, [9]=odd parity, [10]=stop.
  function automatic logic frame_bad(input logic [FRAME_BITS-1:0] frame);
    return frame[0] | ~frame[10] | ~(^frame[9:1]);
  endfunction
endpackage

// File: rtl/ps2_sync_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is accepted only with a pop.
module ps2_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises frames, folds E0/F0
// prefixes into flags and queues one tagged word per key event.
module ps2_kbd_rx_fifo #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_US  = 120,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_ERR    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [10:0]                 rd_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  import ps2_pkg::*;

  localparam int TMAX = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW   = $clog2(TMAX + 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic [TW-1:0]          timer_r;
  logic [3:0]             bit_cnt_r;
  logic [FRAME_BITS-1:0]  shift_r;
  logic                   ext_r;
  logic                   rel_r;
  logic                   overflow_r;

  logic       clk_s, fall_s, edge_s, timeout_s, frame_done_s, frm_err_s;
  logic [7:0] code_s;
  logic       push_s, pop_s, full_s, empty_s;
  ps2_word_t  word_s;

  assign clk_s        = clk_sync_r[SYNC_STAGES-1];
  assign fall_s       = clk_prev_r & ~clk_s;
  assign edge_s       = clk_prev_r ^ clk_s;
  assign timeout_s    = (timer_r == TW'(TMAX));
  assign frame_done_s = (bit_cnt_r == 4'(FRAME_BITS));
  assign frm_err_s    = frame_bad(shift_r);
  assign code_s       = shift_r[8:1];
  assign pop_s        = rd_en & ~empty_s;

  // Word to queue and whether this finished frame produces one.
  always_comb begin
    push_s = 1'b0;
    word_s = '{err: frm_err_s, ext: ext_r, rel: rel_r, code: code_s};
    if (frame_done_s) begin
      if (frm_err_s) push_s = (DROP_ERR == 0);
      else           push_s = (code_s != EXTENDED_CODE) && (code_s != RELEASE_CODE);
    end else begin
      push_s = 1'b0;
    end
  end

  // Pin synchronisers, inactivity timer, frame shifter and prefix flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= '1;
      data_sync_r <= '1;
      clk_prev_r  <= 1'b1;
      timer_r     <= '0;
      bit_cnt_r   <= 4'd0;
      shift_r     <= '0;
      ext_r       <= 1'b0;
      rel_r       <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_s;

      if (edge_s)          timer_r <= '0;
      else if (!timeout_s) timer_r <= timer_r + TW'(1);
      else                 timer_r <= timer_r;

      // A stale partial frame or a just-checked frame restarts the count from this bit.
      if (fall_s) begin
        shift_r   <= {data_sync_r[SYNC_STAGES-1], shift_r[FRAME_BITS-1:1]};
        bit_cnt_r <= (frame_done_s || timeout_s) ? 4'd1 : bit_cnt_r + 4'd1;
      end else if (frame_done_s || timeout_s) begin
        bit_cnt_r <= 4'd0;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      if (frame_done_s) begin
        if (frm_err_s) begin
          ext_r <= 1'b0;
          rel_r <= 1'b0;
        end else if (code_s == EXTENDED_CODE) begin
          ext_r <= 1'b1;
        end else if (code_s == RELEASE_CODE) begin
          rel_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          rel_r <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           overflow_r <= 1'b0;
    else if (push_s && full_s && !pop_s) overflow_r <= 1'b1;
    else if (clr_ovf)                  overflow_r <= 1'b0;
    else                               overflow_r <= overflow_r;
  end

  ps2_sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (word_s),
    .pop     (pop_s),
    .rd_data (rd_data),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count)
  );

  assign rd_valid = ~empty_s;
  assign overflow = overflow_r;
endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed bench: two receivers share the PS/2 pins (A: depth 4, drop bad frames;
// B: depth 8, queue bad frames with err set).
module tb_ps2_kbd_rx_fifo;
  localparam int H = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic        clr_ovf_a = 1'b0, clr_ovf_b = 1'b0;
  logic        rd_valid_a, rd_valid_b, overflow_a, overflow_b;
  logic [10:0] rd_data_a, rd_data_b;
  logic [2:0]  count_a;
  logic [3:0]  count_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  code;
    logic        flip;
    logic        va;
    logic [10:0] wa;
    logic        vb;
    logic [10:0] wb;
  } vec_t;
  vec_t tbl [12];

  always #10 clk = ~clk;

  ps2_kbd_rx_fifo #(.FIFO_DEPTH(4), .DROP_ERR(1)) dut_a (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en_a),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .count(count_a),
    .overflow(overflow_a), .clr_ovf(clr_ovf_a));

  ps2_kbd_rx_fifo #(.FIFO_DEPTH(8), .DROP_ERR(0)) dut_b (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en_b),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .count(count_b),
    .overflow(overflow_b), .clr_ovf(clr_ovf_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drives n bits LSB-first; pulse_sel 1/2 pulses rd_en_a/clr_ovf_a on the push cycle.
  task automatic send_raw(input logic [10:0] bits, input int n, input int pulse_sel);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == n - 1 && pulse_sel != 0) begin
        repeat (3) @(negedge clk);
        if (pulse_sel == 1) rd_en_a = 1'b1;
        else                clr_ovf_a = 1'b1;
        @(negedge clk);
        rd_en_a   = 1'b0;
        clr_ovf_a = 1'b0;
        repeat (H - 4) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic flip);
    return {1'b1, (~^code) ^ flip, code, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] code, input logic flip, input int pulse_sel);
    send_raw(mk_frame(code, flip), 11, pulse_sel);
  endtask

  task automatic pop(input logic a, input logic b);
    rd_en_a = a;
    rd_en_b = b;
    @(negedge clk);
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 11'h01C, 1'b1, 11'h01C};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[2]  = '{8'h1C, 1'b0, 1'b1, 11'h11C, 1'b1, 11'h11C};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[4]  = '{8'h75, 1'b0, 1'b1, 11'h275, 1'b1, 11'h275};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[7]  = '{8'h75, 1'b0, 1'b1, 11'h375, 1'b1, 11'h375};
    tbl[8]  = '{8'h1C, 1'b1, 1'b0, 11'h000, 1'b1, 11'h41C};
    tbl[9]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[10] = '{8'h1C, 1'b1, 1'b0, 11'h000, 1'b1, 11'h61C};
    tbl[11] = '{8'h29, 1'b0, 1'b1, 11'h029, 1'b1, 11'h029};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_valid_a", rd_valid_a, 0);
    chk("rst_data_a", rd_data_a, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_ovf_a", overflow_a, 0);
    chk("rst_count_b", count_b, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Make then break of 'A' without reads
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    chk("a_count2", count_a, 2);
    chk("a_head_make", rd_data_a, 11'h01C);
    chk("b_count2", count_b, 2);
    pop(1'b1, 1'b1);
    chk("a_head_break", rd_data_a, 11'h11C);
    chk("b_head_break", rd_data_b, 11'h11C);
    pop(1'b1, 1'b1);
    chk("a_empty", rd_valid_a, 0);
    chk("b_empty", rd_valid_b, 0);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      send_frame(tbl[i].code, tbl[i].flip, 0);
      chk($sformatf("tbl%0d_valid_a", i), rd_valid_a, tbl[i].va);
      chk($sformatf("tbl%0d_count_a", i), count_a, tbl[i].va);
      chk($sformatf("tbl%0d_valid_b", i), rd_valid_b, tbl[i].vb);
      chk($sformatf("tbl%0d_count_b", i), count_b, tbl[i].vb);
      if (tbl[i].va) chk($sformatf("tbl%0d_data_a", i), rd_data_a, tbl[i].wa);
      if (tbl[i].vb) chk($sformatf("tbl%0d_data_b", i), rd_data_b, tbl[i].wb);
      pop(tbl[i].va, tbl[i].vb);
    end

    // Partial frame abandoned by the inactivity timeout
    send_raw(mk_frame(8'h55, 1'b0), 6, 0);
    repeat (7500) @(negedge clk);
    send_frame(8'h29, 1'b0, 0);
    chk("to_count_a", count_a, 1);
    chk("to_data_a", rd_data_a, 11'h029);
    chk("to_count_b", count_b, 1);
    chk("to_data_b", rd_data_b, 11'h029);
    pop(1'b1, 1'b1);

    // Overflow on the depth-4 receiver
    send_frame(8'h15, 1'b0, 0);
    send_frame(8'h1D, 1'b0, 0);
    send_frame(8'h24, 1'b0, 0);
    send_frame(8'h2D, 1'b0, 0);
    send_frame(8'h2C, 1'b0, 0);
    chk("ovf_count_a", count_a, 4);
    chk("ovf_flag_a", overflow_a, 1);
    chk("ovf_head_a", rd_data_a, 11'h015);
    send_frame(8'h35, 1'b0, 1);
    chk("pushpop_count_a", count_a, 4);
    chk("pushpop_head_a", rd_data_a, 11'h01D);
    clr_ovf_a = 1'b1;
    @(negedge clk);
    clr_ovf_a = 1'b0;
    chk("clr_ovf_a", overflow_a, 0);
    send_frame(8'h3C, 1'b0, 2);
    chk("ovf_wins_clr_a", overflow_a, 1);
    chk("ovf2_count_a", count_a, 4);
    chk("deep_count_b", count_b, 7);
    chk("deep_ovf_b", overflow_b, 0);
    chk("deep_head_b", rd_data_b, 11'h015);

    // Reset in the middle of a frame
    send_raw(mk_frame(8'h6B, 1'b0), 5, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid_a", rd_valid_a, 0);
    chk("mid_rst_data_a", rd_data_a, 0);
    chk("mid_rst_count_a", count_a, 0);
    chk("mid_rst_ovf_a", overflow_a, 0);
    chk("mid_rst_count_b", count_b, 0);
    chk("mid_rst_data_b", rd_data_b, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h16, 1'b0, 0);
    chk("post_rst_count_a", count_a, 1);
    chk("post_rst_data_a", rd_data_a, 11'h016);
    chk("post_rst_count_b", count_b, 1);
    chk("post_rst_data_b", rd_data_b, 11'h016);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
